// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs a req/ack transaction to a variable-latency data
// memory for EX/MEM loads and stores, stalling the upstream pipeline meanwhile.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  input  logic        Zero_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] ReadData2_in,
  output logic        DMem_Req,
  output logic        DMem_We,
  output logic [31:0] DMem_Addr,
  output logic [31:0] DMem_WData,
  input  logic        DMem_Ack,
  input  logic [31:0] DMem_RData,
  output logic        Stall,
  output logic        PCSrc,
  output logic [31:0] ReadData_out,
  output logic        Done,
  output logic        AlignErr,
  output logic        TimeoutErr
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] count;
  logic       access;
  logic       aligned;

  assign access  = MemRead_in | MemWrite_in;
  assign aligned = (ALUResult_in[1:0] == 2'b00);
  assign PCSrc   = Branch_in & Zero_in;

  // Stall must be known in the same cycle the access is presented, so it is
  // decoded from state and inputs rather than registered.
  assign Stall    = !Rst && ((state == WAIT) || (state == IDLE && access && aligned));
  assign AlignErr = !Rst && (state == IDLE) && access && !aligned;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous, so it only acts on a clock edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      count        <= '0;
      DMem_Req     <= 1'b0;
      DMem_We      <= 1'b0;
      DMem_Addr    <= '0;
      DMem_WData   <= '0;
      ReadData_out <= '0;
      Done         <= 1'b0;
      TimeoutErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access && aligned) begin
            DMem_Req   <= 1'b1;
            DMem_We    <= MemWrite_in;
            DMem_Addr  <= ALUResult_in;
            DMem_WData <= ReadData2_in;
            count      <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // A late ack in the final permitted cycle still wins over timeout.
          if (DMem_Ack) begin
            DMem_Req <= 1'b0;
            if (!DMem_We) ReadData_out <= DMem_RData;
            Done     <= 1'b1;
            state    <= DONE;
          end else if (count == LAST_COUNT) begin
            DMem_Req     <= 1'b0;
            TimeoutErr   <= 1'b1;
            ReadData_out <= '0;
            Done         <= 1'b1;
            state        <= DONE;
          end else begin
            count <= count + 8'd1;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_stage_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemRead_in, MemWrite_in, Branch_in, Zero_in;
  logic [31:0] ALUResult_in, ReadData2_in;
  logic        DMem_Req, DMem_We;
  logic [31:0] DMem_Addr, DMem_WData;
  logic        DMem_Ack;
  logic [31:0] DMem_RData;
  logic        Stall, PCSrc, Done, AlignErr, TimeoutErr;
  logic [31:0] ReadData_out;

  mem_stage_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Branch_in(Branch_in), .Zero_in(Zero_in),
    .ALUResult_in(ALUResult_in), .ReadData2_in(ReadData2_in),
    .DMem_Req(DMem_Req), .DMem_We(DMem_We),
    .DMem_Addr(DMem_Addr), .DMem_WData(DMem_WData),
    .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData),
    .Stall(Stall), .PCSrc(PCSrc), .ReadData_out(ReadData_out),
    .Done(Done), .AlignErr(AlignErr), .TimeoutErr(TimeoutErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one in-flight access record plus sticky/captured state.
  typedef struct {
    bit          valid;
    int          waited;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } access_t;

  access_t     flight;
  bit          finishing;
  logic [31:0] m_rdata;
  bit          m_terr;
  bit          m_we_last;
  logic [31:0] m_addr_last, m_wdata_last;
  bit          model_ok = 0;

  int stall_cnt, req_cnt, done_cnt, align_cnt;

  task automatic clear_counts();
    stall_cnt = 0; req_cnt = 0; done_cnt = 0; align_cnt = 0;
  endtask

  task automatic step(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input bit ack, input logic [31:0] rdata,
                      input bit rst, input bit br = 0, input bit z = 0);
    bit acc, idle;
    @(negedge Clk);
    Rst = rst; MemRead_in = rd; MemWrite_in = wr; ALUResult_in = addr;
    ReadData2_in = wd; DMem_Ack = ack; DMem_RData = rdata;
    Branch_in = br; Zero_in = z;
    #1;
    acc  = rd | wr;
    idle = !flight.valid && !finishing;
    check("pcsrc", PCSrc, br & z);
    if (model_ok) begin
      check("req", DMem_Req, flight.valid);
      check("done", Done, finishing);
      check("rdata_out", ReadData_out, m_rdata);
      check("timeout_err", TimeoutErr, m_terr);
      check("stall", Stall, !rst && (flight.valid || (idle && acc && addr[1:0] == 0)));
      check("align_err", AlignErr, !rst && idle && acc && addr[1:0] != 0);
      if (flight.valid) begin
        check("we", DMem_We, flight.we);
        check("addr", DMem_Addr, flight.addr);
        check("wdata", DMem_WData, flight.wdata);
      end
    end
    if (Stall) stall_cnt++;
    if (DMem_Req) req_cnt++;
    if (Done) done_cnt++;
    if (AlignErr) align_cnt++;
    @(posedge Clk);
    if (rst) begin
      flight = '{default: 0}; finishing = 0; m_rdata = '0; m_terr = 0; model_ok = 1;
    end else if (finishing) begin
      finishing = 0;
    end else if (flight.valid) begin
      if (ack) begin
        if (!flight.we) m_rdata = rdata;
        flight.valid = 0; finishing = 1;
      end else if (flight.waited + 1 == int'(TB_TIMEOUT)) begin
        m_rdata = '0; m_terr = 1; flight.valid = 0; finishing = 1;
      end else begin
        flight.waited++;
      end
    end else if (acc && addr[1:0] == 0) begin
      flight = '{valid: 1, waited: 0, we: wr, addr: addr, wdata: wd};
    end
  endtask

  task automatic idle_step(input bit rst = 0);
    step(0, 0, 32'h0, 32'h0, 0, 32'h0, rst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    flight = '{default: 0}; finishing = 0; m_rdata = '0; m_terr = 0;
    idle_step(1);
    idle_step(1);
    idle_step(0);
    check("reset_rdata", ReadData_out, 32'h0);
    check("reset_req", DMem_Req, 1'b0);

    // Load with ack in the first WAIT cycle.
    clear_counts();
    step(1, 0, 32'h10, 32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
    step(1, 0, 32'h10, 32'h0, 0, 32'h0, 0);
    idle_step();
    check("load_stalls", stall_cnt, 2);
    check("load_reqs", req_cnt, 1);
    check("load_dones", done_cnt, 1);
    check("load_data", ReadData_out, 32'hDEADBEEF);

    // Store with ack on the third WAIT cycle.
    clear_counts();
    step(0, 1, 32'h20, 32'h12345678, 0, 32'h0, 0);
    step(0, 1, 32'h20, 32'h12345678, 0, 32'h0, 0);
    step(0, 1, 32'h20, 32'h12345678, 0, 32'h0, 0);
    step(0, 1, 32'h20, 32'h12345678, 1, 32'hFFFFFFFF, 0);
    step(0, 1, 32'h20, 32'h12345678, 0, 32'h0, 0);
    idle_step();
    check("store_stalls", stall_cnt, 4);
    check("store_reqs", req_cnt, 3);
    check("store_keeps_data", ReadData_out, 32'hDEADBEEF);

    // Misaligned load.
    clear_counts();
    step(1, 0, 32'h13, 32'h0, 0, 32'h0, 0);
    idle_step();
    idle_step();
    check("align_pulses", align_cnt, 1);
    check("align_reqs", req_cnt, 0);
    check("align_stalls", stall_cnt, 0);

    // Load with no ack: times out after TB_TIMEOUT WAIT cycles.
    clear_counts();
    step(1, 0, 32'h40, 32'h0, 0, 32'h0, 0);
    repeat (TB_TIMEOUT + 1) step(1, 0, 32'h40, 32'h0, 0, 32'h0, 0);
    repeat (3) idle_step();
    check("to_reqs", req_cnt, TB_TIMEOUT);
    check("to_dones", done_cnt, 1);
    check("to_sticky", TimeoutErr, 1'b1);
    check("to_rdata", ReadData_out, 32'h0);

    // Reset in the second WAIT cycle, late ack afterwards.
    step(1, 0, 32'h44, 32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h44, 32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h44, 32'h0, 0, 32'h0, 1);
    clear_counts();
    step(0, 0, 32'h0, 32'h0, 1, 32'hCAFEF00D, 0);
    check("rst_req", DMem_Req, 1'b0);
    check("rst_terr", TimeoutErr, 1'b0);
    repeat (2) idle_step();
    check("rst_no_done", done_cnt, 0);
    check("rst_no_capture", ReadData_out, 32'h0);

    // Back-to-back loads.
    clear_counts();
    step(1, 0, 32'h100, 32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h100, 32'h0, 1, 32'h1, 0);
    step(1, 0, 32'h100, 32'h0, 0, 32'h0, 0);
    check("b2b_first", ReadData_out, 32'h1);
    step(1, 0, 32'h104, 32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h104, 32'h0, 1, 32'h2, 0);
    step(1, 0, 32'h104, 32'h0, 0, 32'h0, 0);
    idle_step();
    check("b2b_dones", done_cnt, 2);
    check("b2b_second", ReadData_out, 32'h2);

    // Branch resolution.
    step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 1, 1);
    check("pcsrc_taken", PCSrc, 1'b1);
    step(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 1, 0);
    check("pcsrc_not_taken", PCSrc, 1'b0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bit          r_rd, r_wr, r_ack, r_rst;
      logic [31:0] r_addr;
      r_rd   = ($urandom_range(0, 99) < 40);
      r_wr   = ($urandom_range(0, 99) < 30);
      r_ack  = ($urandom_range(0, 99) < 35);
      r_rst  = ($urandom_range(0, 99) < 2);
      r_addr = $urandom;
      if ($urandom_range(0, 99) < 80) r_addr[1:0] = 2'b00;
      step(r_rd, r_wr, r_addr, $urandom, r_ack, $urandom, r_rst,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access controller for the five-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs (control bits, ALU result as address, ReadData2 as store data) and runs a request/acknowledge transaction to a variable-latency data memory. While a transaction is outstanding it stalls the upstream pipeline. It presents captured load data, branch resolution and error flags to the MEM/WB side.

## Interface
Parameters:
- TIMEOUT, 255: maximum WAIT cycles without DMem_Ack before the access is aborted (1..255).

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- MemRead_in  in  1  EX/MEM load control.
- MemWrite_in  in  1  EX/MEM store control.
- Branch_in  in  1  EX/MEM branch control.
- Zero_in  in  1  EX/MEM ALU zero flag.
- ALUResult_in  in  32  effective address.
- ReadData2_in  in  32  store data.
- DMem_Req  out  1  memory request, held until ack.
- DMem_We  out  1  1 = write, 0 = read; valid while DMem_Req = 1.
- DMem_Addr  out  32  latched address.
- DMem_WData  out  32  latched store data.
- DMem_Ack  in  1  memory acknowledge, 1-cycle pulse.
- DMem_RData  in  32  read data, valid with DMem_Ack.
- Stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- PCSrc  out  1  Branch_in & Zero_in, combinational.
- ReadData_out  out  32  captured load data.
- Done  out  1  1-cycle pulse: access finished; MEM/WB may load.
- AlignErr  out  1  1-cycle pulse: misaligned access rejected.
- TimeoutErr  out  1  sticky: an access timed out; cleared only by Rst.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If neither MemRead_in nor MemWrite_in is set, the state is unchanged and Stall = 0.
  - If an access is requested and ALUResult_in[1:0] != 0: AlignErr = 1 this cycle, no memory request, Stall = 0, remain in IDLE.
  - If an aligned access is requested: Stall = 1 combinationally. At the edge, latch DMem_Addr, DMem_WData and DMem_We, clear the counter, and go to WAIT.
  - If MemRead_in and MemWrite_in are both set, the access is a write.
- WAIT:
  - DMem_Req = 1 and Stall = 1. The counter increments each cycle.
  - On DMem_Ack: capture DMem_RData into ReadData_out if the access is a read. ReadData_out is unchanged for a write. Go to DONE.
  - If the counter reaches TIMEOUT without an ack: drop DMem_Req, set TimeoutErr, set ReadData_out = 0, and go to DONE.
- DONE:
  - Done = 1 and Stall = 0. The pipeline advances at this edge.
  - Go to IDLE unconditionally. EX/MEM inputs are not sampled in DONE, so the same instruction is never reissued.
- DMem_Ack outside WAIT is ignored.
- An ack in the same cycle the counter reaches TIMEOUT counts as success: no error, data captured.
- PCSrc is independent of the FSM.

## Timing
- Reset values: state IDLE, DMem_Req 0, DMem_We 0, DMem_Addr 0, DMem_WData 0, ReadData_out 0, Done 0, AlignErr 0, TimeoutErr 0, counter 0. Stall is 0 during reset.
- Rst has priority in every state. Asserting it mid-WAIT drops DMem_Req on the following cycle, and a late ack is ignored.
- Zero-wait memory (ack in the first WAIT cycle): IDLE (Stall) → WAIT (Stall) → DONE. The instruction occupies MEM for 3 cycles with 2 stall cycles.
- Ack in the n-th WAIT cycle: n + 1 stall cycles, and Done rises in cycle n + 2 after the access is seen.
- Timeout: TIMEOUT WAIT cycles, then DONE. DMem_Req is low in DONE.
- ReadData_out is valid from DONE until the next read completes.
- DMem_Addr, DMem_WData and DMem_We are stable for the whole WAIT state.

## Test plan
- Load, addr 0x0000_0010, ack on the 1st WAIT cycle with RData 0xDEAD_BEEF → DMem_Req for 1 cycle with We = 0, Stall high for 2 cycles, Done pulse, ReadData_out = 0xDEAD_BEEF.
- Store, addr 0x0000_0020, data 0x1234_5678, ack after 3 WAIT cycles → DMem_We = 1, Addr and WData stable for 3 cycles, 4 stall cycles, ReadData_out unchanged.
- Load at addr 0x0000_0013 → AlignErr pulses for 1 cycle, DMem_Req never rises, Stall stays 0.
- TIMEOUT = 4, load with no ack → DMem_Req high for 4 cycles then low, TimeoutErr = 1 and sticky, ReadData_out = 0, Done pulses.
- Rst asserted in the 2nd WAIT cycle, ack the next cycle → the next cycle shows all reset values, and the ack causes no capture and no Done.
- Back-to-back loads (second instruction presented after DONE), RData 0x1 then 0x2 → two separate transactions, two Done pulses, ReadData_out = 0x1 then 0x2.
- Branch_in = 1 with Zero_in = 1 → PCSrc = 1 in the same cycle; with Zero_in = 0 → PCSrc = 0.
